// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side bus bundle for the simulink->PPC software register.
// Bit 0 is the MSB on every bus vector, matching OPB numbering.
interface opb_register_simulink2ppc_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic [0:AWIDTH-1]   OPB_ABus;
    logic [0:DWIDTH/8-1] OPB_BE;
    logic [0:DWIDTH-1]   OPB_DBus;
    logic                OPB_RNW;
    logic                OPB_select;
    logic                OPB_seqAddr;
    logic [0:DWIDTH-1]   Sl_DBus;
    logic                Sl_errAck;
    logic                Sl_retry;
    logic                Sl_toutSup;
    logic                Sl_xferAck;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );
endinterface

// File: rtl/opb_register_simulink2ppc.sv
// Fabric->PPC OPB software register with DATA / STATUS / CTRL words.
// Define S2P_HOLD_EN to hold an unread word instead of overwriting it.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h01000600,
    parameter logic [31:0] C_HIGHADDR   = 32'h010006FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst,
    opb_register_simulink2ppc_if.slave   opb,
    input  logic [31:0]                  user_data_in,
    input  logic                         user_data_valid,
    output logic                         user_data_taken
);
    localparam int unused_family_len = $bits(C_FAMILY);

    typedef enum logic [1:0] {IDLE, DEC, ACK, HOLD} state_t;

    state_t                    state, state_nx;
    logic [C_OPB_AWIDTH-1:0]   addr;
    logic [C_OPB_AWIDTH-1:0]   ofs_full;
    logic [C_OPB_DWIDTH-1:0]   wdata;
    logic [C_OPB_DWIDTH-1:0]   rdata;
    logic                      hit;
    logic [7:0]                ofs_q;
    logic                      rnw_q;
    logic                      xfer_ack, tout_sup, rd_data_ack, ctrl_clr;

    logic [31:0]               data_q;
    logic                      fresh_q, ovf_q;
    logic [15:0]               cnt_q;
    logic [31:0]               status;
    logic                      unused_bits;

    // Bus vectors are MSB-at-0, so a plain assignment gives bus[0] = reg[31].
    assign addr     = opb.OPB_ABus;
    assign wdata    = opb.OPB_DBus;
    assign hit      = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign ofs_full = addr - C_BASEADDR;
    assign status   = {fresh_q, ovf_q, 14'b0, cnt_q};

    assign unused_bits = ^{opb.OPB_BE, opb.OPB_seqAddr, wdata[31:1], ofs_full[31:8]};

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (hit) state_nx = DEC;
            // Dropping select before the ack aborts with no side effects.
            DEC:  state_nx = opb.OPB_select ? ACK : IDLE;
            ACK:  state_nx = HOLD;
            HOLD: if (!opb.OPB_select) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        xfer_ack    = (state == ACK);
        tout_sup    = (state == DEC);
        rd_data_ack = xfer_ack && rnw_q && (ofs_q == 8'h00);
        ctrl_clr    = xfer_ack && !rnw_q && (ofs_q == 8'h08) && wdata[0];
        rdata       = '0;
        if (xfer_ack && rnw_q) begin
            case (ofs_q)
                8'h00:   rdata = data_q;
                8'h04:   rdata = status;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ofs_q <= '0;
            rnw_q <= 1'b0;
        end else if (state == DEC) begin
            ofs_q <= ofs_full[7:0];
            rnw_q <= opb.OPB_RNW;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_q  <= '0;
            fresh_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
`ifdef S2P_HOLD_EN
            // An unread word is kept; late words only count and flag overflow.
            if (user_data_valid && !fresh_q) data_q <= user_data_in;
            if (user_data_valid && !fresh_q) fresh_q <= 1'b1;
            else if (rd_data_ack)            fresh_q <= 1'b0;
            if (ctrl_clr)                        ovf_q <= 1'b0;
            else if (user_data_valid && fresh_q) ovf_q <= 1'b1;
`else
            if (user_data_valid) data_q <= user_data_in;
            if (user_data_valid)  fresh_q <= 1'b1;
            else if (rd_data_ack) fresh_q <= 1'b0;
            // A word read in the same cycle it is replaced is not lost.
            if (ctrl_clr)                                        ovf_q <= 1'b0;
            else if (user_data_valid && fresh_q && !rd_data_ack) ovf_q <= 1'b1;
`endif
            if (ctrl_clr)             cnt_q <= {15'b0, user_data_valid};
            else if (user_data_valid) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign opb.Sl_DBus    = rdata;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = tout_sup;
    assign opb.Sl_xferAck = xfer_ack;
    assign user_data_taken = rd_data_ack;
endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Randomized bench for opb_register_simulink2ppc against a transaction-level model.
module tb_opb_register_simulink2ppc;
    localparam logic [31:0] BASE = 32'h01000600;
    localparam logic [31:0] HIGH = 32'h010006FF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        dv;
    logic        taken;
    int          checks = 0;
    int          errors = 0;
    int          taken_cnt = 0;

    opb_register_simulink2ppc_if bus();

    opb_register_simulink2ppc dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .opb(bus),
        .user_data_in(din), .user_data_valid(dv), .user_data_taken(taken)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (taken === 1'b1) taken_cnt++;

    // model state
    logic [31:0] m_data;
    bit          m_fresh, m_ovf;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_data = 0; m_fresh = 0; m_ovf = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] o);
        if (o == 8'h00) return m_data;
        if (o == 8'h04) return {m_fresh, m_ovf, 14'b0, m_cnt};
        return 32'h0;
    endfunction

    // One cycle of register behaviour: capture v/d, DATA read rd, CTRL clear clr.
    task automatic m_apply(input bit v, input logic [31:0] d, input bit rd, input bit clr);
        bit f0;
        f0 = m_fresh;
        if (clr) begin m_ovf = 0; m_cnt = 0; end
        if (v) begin
            m_cnt = m_cnt + 1;
`ifdef S2P_HOLD_EN
            if (f0 && !clr) m_ovf = 1;
            if (!f0) begin m_data = d; m_fresh = 1; end
            else if (rd) m_fresh = 0;
`else
            if (f0 && !rd && !clr) m_ovf = 1;
            m_data = d; m_fresh = 1;
`endif
        end else if (rd) m_fresh = 0;
    endtask

    task automatic tick(input bit v, input logic [31:0] d);
        dv = v; din = d;
        @(posedge clk); #1;
        dv = 0;
    endtask

    task automatic idle(input bit v, input logic [31:0] d);
        tick(v, d);
        m_apply(v, d, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1; tick(0, 0); tick(0, 0); rst = 0;
        m_reset();
    endtask

    // Full transfer; v/d is the capture driven during the ack cycle.
    task automatic xfer(input logic [31:0] a, input bit rnw, input logic [31:0] wd,
                        input bit v, input logic [31:0] d, output logic [31:0] rd);
        logic [7:0]  o;
        bit          inwin;
        logic [31:0] exp;
        bus.OPB_ABus = a; bus.OPB_RNW = rnw; bus.OPB_DBus = rnw ? 32'h0 : wd;
        bus.OPB_select = 1;
        rd = 32'h0;
        inwin = (a >= BASE) && (a <= HIGH);
        tick(0, 0);
        chk("ack_n1", {31'b0, bus.Sl_xferAck}, 32'h0);
        chk("tout_n1", {31'b0, bus.Sl_toutSup}, {31'b0, inwin});
        tick(0, 0);
        chk("ack_n2", {31'b0, bus.Sl_xferAck}, {31'b0, inwin});
        if (inwin) begin
            o = 8'(a - BASE);
            exp = rnw ? m_read(o) : 32'h0;
            rd = bus.Sl_DBus;
            chk("rdata", bus.Sl_DBus, exp);
            chk("taken", {31'b0, taken}, {31'b0, (rnw && o == 8'h00)});
            tick(v, d);
            m_apply(v, d, rnw && o == 8'h00, !rnw && o == 8'h08 && wd[0]);
            chk("no_dbl_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
        end else begin
            tick(v, d);
            m_apply(v, d, 0, 0);
            chk("no_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
        end
        bus.OPB_select = 0;
        tick(0, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          acks;
        rst = 1; dv = 0; din = 0;
        bus.OPB_ABus = 0; bus.OPB_BE = 4'hF; bus.OPB_DBus = 0;
        bus.OPB_RNW = 0; bus.OPB_select = 0; bus.OPB_seqAddr = 0;
        m_reset();
        tick(0, 0); tick(0, 0);
        chk("rst_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
        chk("rst_dbus", bus.Sl_DBus, 32'h0);
        chk("rst_tout", {31'b0, bus.Sl_toutSup}, 32'h0);
        chk("rst_taken", {31'b0, taken}, 32'h0);
        rst = 0;
        xfer(BASE + 4, 1, 0, 0, 0, r);
        chk("rst_status", r, 32'h0);

        // reset landing in the ack cycle
        idle(1, 32'hA5A5A5A5);
        bus.OPB_ABus = BASE; bus.OPB_RNW = 1; bus.OPB_select = 1;
        tick(0, 0); tick(0, 0);
        rst = 1; tick(0, 0);
        chk("rstack_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
        chk("rstack_dbus", bus.Sl_DBus, 32'h0);
        rst = 0; bus.OPB_select = 0; m_reset(); tick(0, 0);
        xfer(BASE + 4, 1, 0, 0, 0, r);
        chk("rstack_status", r, 32'h0);

        // basic capture and read
        idle(1, 32'hDEADBEEF);
        taken_cnt = 0;
        xfer(BASE, 1, 0, 0, 0, r);
        chk("deadbeef", r, 32'hDEADBEEF);
        xfer(BASE + 4, 1, 0, 0, 0, r);
        chk("status_after_rd", r, 32'h00000001);
        chk("taken_once", taken_cnt, 1);

        // two captures, no read
        do_reset();
        idle(1, 32'h1); idle(1, 32'h2);
        xfer(BASE + 4, 1, 0, 0, 0, r);
        chk("two_cap_status", r, 32'hC0000002);
        xfer(BASE, 1, 0, 0, 0, r);
`ifdef S2P_HOLD_EN
        chk("two_cap_data", r, 32'h1);
`else
        chk("two_cap_data", r, 32'h2);
`endif

        // clear, then count wrap
        do_reset();
        idle(1, 32'h7);
        xfer(BASE + 8, 0, 32'h1, 0, 0, r);
        xfer(BASE + 4, 1, 0, 0, 0, r);
        chk("clr_status", r, 32'h80000000);
        for (int i = 0; i < 65536; i++) idle(1, i);
        xfer(BASE + 4, 1, 0, 0, 0, r);
        chk("wrap_status", r, 32'hC0000000);

        // select held high: exactly one ack
        bus.OPB_ABus = BASE + 4; bus.OPB_RNW = 1; bus.OPB_select = 1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, 0);
            if (bus.Sl_xferAck === 1'b1) acks++;
        end
        bus.OPB_select = 0; tick(0, 0);
        chk("one_ack", acks, 1);

        // window edges and unmapped offset
        xfer(HIGH + 4, 1, 0, 0, 0, r);
        xfer(BASE - 4, 1, 0, 0, 0, r);
        xfer(BASE + 32'h10, 1, 0, 0, 0, r);
        chk("ofs10_data", r, 32'h0);

        // capture coinciding with DATA read ack
        do_reset();
        idle(1, 32'h11);
        xfer(BASE, 1, 0, 1, 32'h22, r);
        chk("coinc_old", r, 32'h11);
        xfer(BASE + 4, 1, 0, 0, 0, r);
`ifdef S2P_HOLD_EN
        chk("coinc_status", r, 32'h40000002);
`else
        chk("coinc_status", r, 32'h80000002);
`endif

        // abort in DEC: CTRL clear must not take effect
        do_reset();
        idle(1, 32'h5); idle(1, 32'h6);
        bus.OPB_ABus = BASE + 8; bus.OPB_RNW = 0; bus.OPB_DBus = 32'h1; bus.OPB_select = 1;
        tick(0, 0);
        bus.OPB_select = 0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            chk("abort_no_ack", {31'b0, bus.Sl_xferAck}, 32'h0);
        end
        xfer(BASE + 4, 1, 0, 0, 0, r);
        chk("abort_status", r, 32'hC0000002);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          k;
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) idle($urandom_range(0, 1) == 1, $urandom);
            case ($urandom_range(0, 5))
                0, 1:    a = BASE;
                2:       a = BASE + 4;
                3:       a = BASE + 8;
                4:       a = BASE + 32'h10 + 4 * $urandom_range(0, 59);
                default: a = HIGH + 1 + 4 * $urandom_range(0, 3);
            endcase
            xfer(a, $urandom_range(0, 2) != 0, {$urandom_range(0, 255), 24'h0} | {31'b0, $urandom_range(0, 3) == 0},
                 $urandom_range(0, 2) == 0, $urandom, r);
        end
        xfer(BASE + 4, 1, 0, 0, 0, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
